// File: rtl/cfg_loader.sv
// cfg_loader: accepts configuration words over valid/ready and shifts them MSB-first into the LE config chain.
// Optional CRC-8 trailer check is compiled in by defining CFG_CRC_EN (WORD_W must then be 8).
module cfg_loader #(
  parameter int NUM_LE  = 4,
  parameter int LE_BITS = 17,
  parameter int WORD_W  = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic              start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              cfg_data,
  output logic              cfg_en,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CHAIN_LEN = NUM_LE * LE_BITS;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam int WCNT_W    = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WCNT_W-1:0] LAST_WBIT = WCNT_W'(WORD_W - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CHECK, DONE} state_t;

  state_t            state;
  logic [WORD_W-1:0] word_q;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WCNT_W-1:0] wbit_cnt;

  // The chain is clocked every cycle, so shift enable must follow en combinationally.
  assign s_ready  = (state == LOAD) && en;
  assign cfg_en   = (state == SHIFT) && en;
  assign cfg_data = word_q[WORD_W-1];

`ifdef CFG_CRC_EN
  logic [7:0] crc;
  logic       trailer;
  logic       error_q;
  logic       crc_fb;

  assign crc_fb = crc[7] ^ word_q[WORD_W-1];
  assign error  = error_q;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state    <= IDLE;
      word_q   <= '0;
      bit_cnt  <= '0;
      wbit_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef CFG_CRC_EN
      crc      <= '0;
      trailer  <= 1'b0;
      error_q  <= 1'b0;
`endif
    end else if (en) begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD;
            busy    <= 1'b1;
            bit_cnt <= '0;
`ifdef CFG_CRC_EN
            crc     <= '0;
            trailer <= 1'b0;
            error_q <= 1'b0;
`endif
          end
        end

        LOAD: begin
          if (s_valid) begin
            word_q   <= s_data;
            wbit_cnt <= '0;
`ifdef CFG_CRC_EN
            state    <= trailer ? CHECK : SHIFT;
`else
            state    <= SHIFT;
`endif
          end
        end

        // Chain length wins over word boundary: leftover low bits of the last word are dropped.
        SHIFT: begin
          word_q   <= {word_q[WORD_W-2:0], 1'b0};
          bit_cnt  <= bit_cnt + CNT_W'(1);
          wbit_cnt <= wbit_cnt + WCNT_W'(1);
`ifdef CFG_CRC_EN
          crc      <= {crc[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
`endif
          if (bit_cnt == LAST_BIT) begin
`ifdef CFG_CRC_EN
            state   <= LOAD;
            trailer <= 1'b1;
`else
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
`endif
          end else if (wbit_cnt == LAST_WBIT) begin
            state <= LOAD;
          end
        end

`ifdef CFG_CRC_EN
        CHECK: begin
          if (word_q != crc) error_q <= 1'b1;
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
`endif

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
